// File: rtl/gaussian_blur_3x3.sv
// Streaming 3x3 Gaussian blur: two line buffers feed a 3x3 window register,
// followed by a two-stage weighted-sum / shift pipeline.
module gaussian_blur_3x3 #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int PIX_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIX_W-1:0]     pixel_in,
    input  logic                 pixel_in_valid,
    output logic [9*PIX_W-1:0]   window_out,
    output logic                 window_valid,
    output logic [PIX_W-1:0]     gaussian_pixel_out,
    output logic                 gaussian_pixel_out_valid
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int SUM_W = PIX_W + 4;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic               accept;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   rd_addr;

    logic [PIX_W-1:0]   lb0_mem [IMG_WIDTH];
    logic [PIX_W-1:0]   lb1_mem [IMG_WIDTH];
    logic [PIX_W-1:0]   lb0_rd_q;
    logic [PIX_W-1:0]   lb1_rd_q;

    logic [PIX_W-1:0]   win_q [9];
    logic [PIX_W-1:0]   new_col [3];
    logic               window_valid_q;

    logic [SUM_W-1:0]   sum_d, sum_q;
    logic               s1_valid_q;
    logic [PIX_W-1:0]   pix_q;
    logic               out_valid_q;
    logic               unused_sum_lsbs;

    assign accept = pixel_in_valid & ~rst;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // The RAMs are read one cycle ahead at the next column, so the registered
    // read data already holds LB0[c]/LB1[c] when pixel c is accepted.
    assign rd_addr = rst ? '0 : col_d;

    always_ff @(posedge clk) begin
        if (accept) begin
            lb0_mem[col_q] <= lb1_rd_q;
            lb1_mem[col_q] <= pixel_in;
        end
        lb0_rd_q <= lb0_mem[rd_addr];
        lb1_rd_q <= lb1_mem[rd_addr];
    end

    assign new_col[0] = lb0_rd_q;
    assign new_col[1] = lb1_rd_q;
    assign new_col[2] = pixel_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
            window_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[3*r]   <= win_q[3*r+1];
                    win_q[3*r+1] <= win_q[3*r+2];
                    win_q[3*r+2] <= new_col[r];
                end
            end
            window_valid_q <= accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
        end
    end

    for (genvar gi = 0; gi < 9; gi++) begin : g_win_out
        assign window_out[gi*PIX_W +: PIX_W] = win_q[gi];
    end

    assign window_valid = window_valid_q;

    // Weights 1 2 1 / 2 4 2 / 1 2 1; worst case 16*255 fits in SUM_W bits.
    always_comb begin
        sum_d = SUM_W'(win_q[0])        + (SUM_W'(win_q[1]) << 1) + SUM_W'(win_q[2])
              + (SUM_W'(win_q[3]) << 1) + (SUM_W'(win_q[4]) << 2) + (SUM_W'(win_q[5]) << 1)
              + SUM_W'(win_q[6])        + (SUM_W'(win_q[7]) << 1) + SUM_W'(win_q[8]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            s1_valid_q  <= 1'b0;
            pix_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            s1_valid_q <= window_valid_q;
            if (s1_valid_q) begin
                pix_q <= sum_q[SUM_W-1:4];
            end
            out_valid_q <= s1_valid_q;
        end
    end

    assign unused_sum_lsbs          = &{1'b0, sum_q[3:0]};
    assign gaussian_pixel_out       = pix_q;
    assign gaussian_pixel_out_valid = out_valid_q;

endmodule

// File: tb/tb_gaussian_blur_3x3.sv
// Directed bench for gaussian_blur_3x3 on an 8x8 image: constant, ramp,
// impulse, gapped-input and mid-frame reset frames.
module tb_gaussian_blur_3x3;

    localparam int W = 8;
    localparam int H = 8;
    localparam int NOUT = (W - 2) * (H - 2);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   pixel_in = '0;
    logic         pixel_in_valid = 1'b0;
    logic [71:0]  window_out;
    logic         window_valid;
    logic [7:0]   gaussian_pixel_out;
    logic         gaussian_pixel_out_valid;

    gaussian_blur_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) u_dut (
        .clk                      (clk),
        .rst                      (rst),
        .pixel_in                 (pixel_in),
        .pixel_in_valid           (pixel_in_valid),
        .window_out               (window_out),
        .window_valid             (window_valid),
        .gaussian_pixel_out       (gaussian_pixel_out),
        .gaussian_pixel_out_valid (gaussian_pixel_out_valid)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        acc_last = 1'b0;
    int          idle_viol = 0;
    int          acc22 = 0;
    logic [7:0]  out_val [$];
    int          out_cyc [$];
    int          wv_cyc [$];
    logic [71:0] first_win = '0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        acc_last <= pixel_in_valid;
    end

    always @(negedge clk) begin
        if (gaussian_pixel_out_valid) begin
            out_val.push_back(gaussian_pixel_out);
            out_cyc.push_back(cyc);
        end
        if (window_valid) begin
            if (wv_cyc.size() == 0) first_win = window_out;
            wv_cyc.push_back(cyc);
            if (!acc_last) idle_viol++;
        end
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_of(input int mode, input int r, input int c);
        case (mode)
            0:       return 8'd100;
            1:       return 8'd255;
            2:       return 8'(10 * c);
            default: return (r == 4 && c == 4) ? 8'd16 : 8'd0;
        endcase
    endfunction

    // Expected blurred value for the output centred on (r, c).
    function automatic logic [7:0] exp_of(input int mode, input int r, input int c);
        int dr, dc;
        dr = (r > 4) ? r - 4 : 4 - r;
        dc = (c > 4) ? c - 4 : 4 - c;
        case (mode)
            0:       return 8'd100;
            1:       return 8'd255;
            2:       return 8'(10 * c);
            default: begin
                if (dr == 0 && dc == 0)      return 8'd4;
                else if (dr + dc == 1)       return 8'd2;
                else if (dr == 1 && dc == 1) return 8'd1;
                else                         return 8'd0;
            end
        endcase
    endfunction

    task automatic send_pixels(input int mode, input int max_gap, input int nrows, input int ncols_last);
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < ((r == nrows - 1) ? ncols_last : W); c++) begin
                @(negedge clk);
                pixel_in       = pix_of(mode, r, c);
                pixel_in_valid = 1'b1;
                if (r == 2 && c == 2) acc22 = cyc + 1;
                if (max_gap > 0) begin
                    repeat ($urandom_range(0, max_gap)) begin
                        @(negedge clk);
                        pixel_in_valid = 1'b0;
                        pixel_in       = 8'hEE;
                    end
                end
            end
        end
        @(negedge clk);
        pixel_in_valid = 1'b0;
    endtask

    task automatic clear_capture();
        out_val.delete();
        out_cyc.delete();
        wv_cyc.delete();
        idle_viol = 0;
    endtask

    task automatic check_frame(input int mode, input string tag, input logic [71:0] exp_win);
        int n, lat_bad;
        repeat (6) @(negedge clk);
        check({tag, "_outcount"}, 72'(out_val.size()), 72'(NOUT));
        check({tag, "_wvcount"}, 72'(wv_cyc.size()), 72'(NOUT));
        n = (out_val.size() < NOUT) ? out_val.size() : NOUT;
        for (int j = 0; j < n; j++) begin
            check($sformatf("%s_px%0d_r%0d_c%0d", tag, j, j / (W - 2) + 1, j % (W - 2) + 1),
                  72'(out_val[j]), 72'(exp_of(mode, j / (W - 2) + 1, j % (W - 2) + 1)));
        end
        lat_bad = 0;
        for (int j = 0; j < n && j < wv_cyc.size(); j++) begin
            if (out_cyc[j] - wv_cyc[j] != 2) lat_bad++;
        end
        check({tag, "_latency_bad"}, 72'(lat_bad), 72'(0));
        if (wv_cyc.size() > 0) check({tag, "_first_wv_cyc"}, 72'(wv_cyc[0]), 72'(acc22));
        check({tag, "_first_win"}, first_win, exp_win);
        check({tag, "_idle_viol"}, 72'(idle_viol), 72'(0));
        clear_capture();
    endtask

    initial begin
        logic [71:0] ramp_win;
        ramp_win = 72'h140A00_140A00_140A00;

        repeat (3) @(negedge clk);
        check("reset_window_out", window_out, 72'(0));
        check("reset_window_valid", 72'(window_valid), 72'(0));
        check("reset_pix_out", 72'(gaussian_pixel_out), 72'(0));
        check("reset_pix_valid", 72'(gaussian_pixel_out_valid), 72'(0));
        rst = 1'b0;

        send_pixels(0, 0, H, W);
        check_frame(0, "const100", {9{8'd100}});
        send_pixels(1, 0, H, W);
        check_frame(1, "const255", {9{8'd255}});
        send_pixels(2, 0, H, W);
        check_frame(2, "ramp", ramp_win);
        send_pixels(3, 0, H, W);
        check_frame(3, "impulse", 72'(0));
        send_pixels(2, 3, H, W);
        check_frame(2, "ramp_gaps", ramp_win);

        // Abort mid row 3, then restart with a clean frame.
        send_pixels(2, 0, 4, 4);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst_wv_%0d", k), 72'(window_valid), 72'(0));
            check($sformatf("rst_ov_%0d", k), 72'(gaussian_pixel_out_valid), 72'(0));
        end
        check("rst_pix_out", 72'(gaussian_pixel_out), 72'(0));
        rst = 1'b0;
        clear_capture();
        send_pixels(2, 0, H, W);
        check_frame(2, "ramp_after_rst", ramp_win);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
